// File: rtl/pulse_period_ms.sv
// ---------------------------------------------------------------------------
// pulse_period_ms
//
// Measures the time between consecutive rising edges of an asynchronous
// pulse and reports it in whole milliseconds. A prescaler divides clk into
// 1 ms ticks, an elapsed counter accumulates ticks between edges, and a
// two-state FSM (ARM / MEASURE) captures the count on every edge after the
// first. Overflow beyond MAX_MS either clamps or wraps, selected by SATURATE.
//
// Parameters:
//   CYCLES_PER_MS  clk cycles per millisecond (>= 2)
//   MS_BITS        width of the ms output
//   MAX_MS         largest reportable value (< 2**MS_BITS)
//   SATURATE       1: clamp at MAX_MS, 0: wrap modulo MAX_MS+1
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high reset
//   pulse_in  in   asynchronous pulse; rising edges delimit a period
//   latch     in   1 holds ms / valid / overflow
//   ms        out  last measured period in ms
//   valid     out  at least one full period has been measured
//   overflow  out  last period exceeded MAX_MS
// ---------------------------------------------------------------------------
module pulse_period_ms #(
    parameter int CYCLES_PER_MS = 50000,
    parameter int MS_BITS       = 11,
    parameter int MAX_MS        = 1999,
    parameter bit SATURATE      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pulse_in,
    input  logic               latch,
    output logic [MS_BITS-1:0] ms,
    output logic               valid,
    output logic               overflow
);

    localparam int PW = (CYCLES_PER_MS > 2) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(CYCLES_PER_MS - 1);
    localparam logic [MS_BITS-1:0] MS_LAST    = MS_BITS'(MAX_MS);

    typedef enum logic {
        ARM,
        MEASURE
    } state_t;

    state_t             state;
    logic               sync1, sync2, sync3;
    logic [PW-1:0]      presc;
    logic [MS_BITS-1:0] elapsed;
    logic               ovf;
    logic [MS_BITS-1:0] res_ms;
    logic               res_valid;
    logic               res_ovf;

    logic               pulse_edge;
    logic               tick;
    logic [MS_BITS-1:0] elapsed_next;
    logic               ovf_next;

    // sync3 is one cycle behind sync2, so this is a one-cycle rising-edge strobe.
    assign pulse_edge = sync2 & ~sync3;
    assign tick       = (presc == PRESC_LAST);

    // Elapsed count after applying this cycle's tick. Used both for normal
    // counting and for the capture, so a tick coinciding with an edge lands
    // in the captured value and is not carried into the next period.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise
        // a latch is inferred for the paths that leave them untouched.
        elapsed_next = elapsed;
        ovf_next     = ovf;
        if (tick) begin
            if (elapsed == MS_LAST) begin
                ovf_next     = 1'b1;
                elapsed_next = SATURATE ? MS_LAST : '0;
            end else begin
                elapsed_next = elapsed + MS_BITS'(1);
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain the synchronizer
    // stages into one and reorder reads against writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARM;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            presc     <= '0;
            elapsed   <= '0;
            ovf       <= 1'b0;
            res_ms    <= '0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
            ms        <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
            sync3 <= sync2;

            // Measurement keeps running while latched; release shows the
            // most recent result.
            if (!latch) begin
                ms       <= res_ms;
                valid    <= res_valid;
                overflow <= res_ovf;
            end

            case (state)
                ARM: begin
                    // First edge only starts the clock; nothing is captured.
                    if (pulse_edge) begin
                        presc   <= '0;
                        elapsed <= '0;
                        ovf     <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (pulse_edge) begin
                        res_ms    <= elapsed_next;
                        res_ovf   <= ovf_next;
                        res_valid <= 1'b1;
                        presc     <= '0;
                        elapsed   <= '0;
                        ovf       <= 1'b0;
                    end else begin
                        presc   <= tick ? '0 : presc + PW'(1);
                        elapsed <= elapsed_next;
                        ovf     <= ovf_next;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_period_ms.sv
// ---------------------------------------------------------------------------
// tb_pulse_period_ms
//
// Drives two instances of pulse_period_ms (saturating and wrapping) from the
// same stimulus and compares both against a period-level reference model:
// captured value = floor(period / CYCLES_PER_MS), then clamped or taken
// modulo MAX_MS+1, with overflow when the quotient exceeds MAX_MS.
// ---------------------------------------------------------------------------
module tb_pulse_period_ms;

    localparam int CPM   = 4;
    localparam int MSB   = 5;
    localparam int MAXMS = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic           pulse_in;
    logic           latch;
    logic [MSB-1:0] ms_s, ms_w;
    logic           valid_s, valid_w, ovf_s, ovf_w;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rise = 0;

    // Reference model: latest result and what the outputs should show.
    bit             armed     = 1'b0;
    logic [MSB-1:0] res_ms_s  = '0, res_ms_w = '0, out_ms_s = '0, out_ms_w = '0;
    logic           res_valid = 1'b0, res_ovf = 1'b0, out_valid = 1'b0, out_ovf = 1'b0;
    logic [13:0]    pre_got, pre_exp;

    pulse_period_ms #(
        .CYCLES_PER_MS(CPM), .MS_BITS(MSB), .MAX_MS(MAXMS), .SATURATE(1'b1)
    ) dut_sat (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .latch(latch),
        .ms(ms_s), .valid(valid_s), .overflow(ovf_s)
    );

    pulse_period_ms #(
        .CYCLES_PER_MS(CPM), .MS_BITS(MSB), .MAX_MS(MAXMS), .SATURATE(1'b0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .latch(latch),
        .ms(ms_w), .valid(valid_w), .overflow(ovf_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    function automatic logic [13:0] got();
        return {ms_s, valid_s, ovf_s, ms_w, valid_w, ovf_w};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {out_ms_s, out_valid, out_ovf, out_ms_w, out_valid, out_ovf};
    endfunction

    function automatic string fmt(logic [13:0] v);
        return $sformatf("sat(ms=%0d v=%b o=%b) wrap(ms=%0d v=%b o=%b)",
                         v[13:9], v[8], v[7], v[6:2], v[1], v[0]);
    endfunction

    function automatic void model_capture(int p);
        int n;
        n         = p / CPM;
        res_ovf   = (n > MAXMS);
        res_ms_s  = MSB'(res_ovf ? MAXMS : n);
        res_ms_w  = MSB'(n % (MAXMS + 1));
        res_valid = 1'b1;
    endfunction

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Raise pulse_in now; sample outputs one cycle before and at the point
    // where the capture becomes visible (rise + 3 and rise + 4 negedges).
    task automatic finish_rise(int p);
        pulse_in  = 1'b1;
        last_rise = cyc;
        wait_until(last_rise + 3);
        pre_got = got();
        pre_exp = exp_vec();
        wait_until(last_rise + 4);
        if (armed) model_capture(p);
        else armed = 1'b1;
        if (!latch) begin
            out_ms_s  = res_ms_s;
            out_ms_w  = res_ms_w;
            out_valid = res_valid;
            out_ovf   = res_ovf;
        end
    endtask

    // Next rising edge exactly p cycles after the previous one (p >= 8).
    task automatic rise_after(int p);
        wait_until(last_rise + p / 2);
        pulse_in = 1'b0;
        wait_until(last_rise + p);
        finish_rise(p);
    endtask

    task automatic set_latch(bit l);
        latch = l;
        if (!l) begin
            out_ms_s  = res_ms_s;
            out_ms_w  = res_ms_w;
            out_valid = res_valid;
            out_ovf   = res_ovf;
        end
    endtask

    task automatic apply_reset(int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        armed = 1'b0;
        res_ms_s = '0; res_ms_w = '0; res_valid = 1'b0; res_ovf = 1'b0;
        out_ms_s = '0; out_ms_w = '0; out_valid = 1'b0; out_ovf = 1'b0;
    endtask

    task automatic test_reset();
        pulse_in = 1'b0;
        latch    = 1'b0;
        apply_reset(2);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_state: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
        repeat (3) @(negedge clk);
        finish_rise(0);
        total++;
        if (pre_got !== pre_exp) begin
            bad++;
            $display("FAIL first_edge_pre: actual %s required %s", fmt(pre_got), fmt(pre_exp));
        end
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL first_edge_arms: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
    endtask

    task automatic test_exact_period();
        int ps[3] = '{40, 43, 44};
        for (int i = 0; i < 3; i++) begin
            rise_after(ps[i]);
            total++;
            if (pre_got !== pre_exp) begin
                bad++;
                $display("FAIL exact_%0d_pre: actual %s required %s", ps[i], fmt(pre_got), fmt(pre_exp));
            end
            total++;
            if (got() !== exp_vec()) begin
                bad++;
                $display("FAIL exact_%0d: actual %s required %s", ps[i], fmt(got()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_overflow();
        int ps[2] = '{80, 8};
        for (int i = 0; i < 2; i++) begin
            rise_after(ps[i]);
            total++;
            if (pre_got !== pre_exp) begin
                bad++;
                $display("FAIL overflow_%0d_pre: actual %s required %s", ps[i], fmt(pre_got), fmt(pre_exp));
            end
            total++;
            if (got() !== exp_vec()) begin
                bad++;
                $display("FAIL overflow_%0d: actual %s required %s", ps[i], fmt(got()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_latch_hold();
        rise_after(40);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL latch_setup: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
        set_latch(1'b1);
        rise_after(24);
        repeat (5) @(negedge clk);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL latch_held: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
        set_latch(1'b0);
        @(negedge clk);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL latch_release: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
    endtask

    task automatic test_reset_mid();
        int p;
        rise_after(40);
        wait_until(last_rise + 10);
        pulse_in = 1'b0;
        wait_until(last_rise + 20);
        apply_reset(1);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_mid_clear: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
        repeat (6) @(negedge clk);
        finish_rise(0);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_mid_rearm: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
        p = $urandom_range(8, 60);
        rise_after(p);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_mid_next_p%0d: actual %s required %s", p, fmt(got()), fmt(exp_vec()));
        end
    endtask

    task automatic test_simultaneous();
        int ns[4] = '{3, 8, 15, 16};
        for (int i = 0; i < 4; i++) begin
            rise_after(CPM * ns[i]);
            total++;
            if (pre_got !== pre_exp) begin
                bad++;
                $display("FAIL simul_n%0d_pre: actual %s required %s", ns[i], fmt(pre_got), fmt(pre_exp));
            end
            total++;
            if (got() !== exp_vec()) begin
                bad++;
                $display("FAIL simul_n%0d: actual %s required %s", ns[i], fmt(got()), fmt(exp_vec()));
            end
        end
    endtask

    // A 1-cycle low glitch may or may not register; only the first clean
    // period after two clean edges is compared.
    task automatic test_glitch();
        wait_until(last_rise + 6);
        pulse_in = 1'b0;
        @(negedge clk);
        finish_rise(cyc - last_rise);
        rise_after(20);
        rise_after(28);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL glitch_recover: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
    endtask

    task automatic test_random();
        int p;
        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(8, 90);
            set_latch($urandom_range(0, 3) == 0);
            rise_after(p);
            total++;
            if (pre_got !== pre_exp) begin
                bad++;
                $display("FAIL rand%0d_p%0d_pre: actual %s required %s", i, p, fmt(pre_got), fmt(pre_exp));
            end
            total++;
            if (got() !== exp_vec()) begin
                bad++;
                $display("FAIL rand%0d_p%0d_l%0b: actual %s required %s", i, p, latch, fmt(got()), fmt(exp_vec()));
            end
        end
        set_latch(1'b0);
        @(negedge clk);
        total++;
        if (got() !== exp_vec()) begin
            bad++;
            $display("FAIL rand_final_release: actual %s required %s", fmt(got()), fmt(exp_vec()));
        end
    endtask

    initial begin
        reset    = 1'b1;
        pulse_in = 1'b0;
        latch    = 1'b0;
        test_reset();
        test_exact_period();
        test_overflow();
        test_latch_hold();
        test_reset_mid();
        test_simultaneous();
        test_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
